// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides and registered result/flags.
// Simple ops finish one cycle after accept. HAM and POP count CHUNK bits per cycle,
// starting at the least significant chunk.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high; operands and opcode latched on in_valid
// EXEC  | simple op: one cycle; HAM/POP: one chunk counted per cycle
// DONE  | out_valid high; s/z/c/v held until out_ready
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int SHW    = $clog2(WIDTH);
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // 1001 and 1101 are taken out of the x001/x101 patterns:
    // 1001 is POP, and 1101 is reserved and returns zero.
    localparam logic [3:0] OP_HAM = 4'b1011;
    localparam logic [3:0] OP_POP = 4'b1001;
    localparam logic [3:0] OP_RSV = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_cnt_src;
    logic [CW-1:0]      r_chunks_left;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_s;
    logic               r_z;
    logic               r_c;
    logic               r_v;

    logic               w_accept;
    logic               w_is_cnt;
    logic               w_last_chunk;
    logic [WIDTH-1:0]   w_chunk_pc;
    logic [WIDTH-1:0]   w_cnt_sum;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;

    function automatic logic [WIDTH-1:0] f_popcount(input logic [CHUNK-1:0] x);
        logic [WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + WIDTH'(x[i]);
        end
        return cnt;
    endfunction

    assign w_accept     = in_valid && (r_state == S_IDLE);
    assign w_is_cnt     = (r_op == OP_HAM) || (r_op == OP_POP);
    assign w_last_chunk = (r_chunks_left == '0);
    assign w_chunk_pc   = f_popcount(r_cnt_src[CHUNK-1:0]);
    assign w_cnt_sum    = r_acc + w_chunk_pc;

    // Single-cycle result and flags from the latched operands.
    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_diff = r_a - r_b;
        w_sh   = r_a[SHW-1:0];
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        if (r_op == OP_POP || r_op == OP_HAM || r_op == OP_RSV) begin
            w_res = '0;
        end else begin
            case (r_op[1:0])
                2'b00: begin
                    if (!r_op[2]) begin
                        w_res = w_sum[WIDTH-1:0];
                        w_c   = w_sum[WIDTH];
                        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                (w_sum[WIDTH-1] != r_a[WIDTH-1]);
                    end else begin
                        w_res = w_diff;
                        w_c   = (r_a < r_b);
                        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                (w_diff[WIDTH-1] != r_a[WIDTH-1]);
                    end
                end
                2'b01:   w_res = r_op[2] ? (r_a | r_b) : (r_a & r_b);
                2'b10:   w_res = r_op[2] ? (r_b << (WIDTH / 2)) : (r_a ^ r_b);
                default: begin
                    case (r_op)
                        4'b0011: w_res = r_b << w_sh;
                        4'b0111: w_res = r_b >> w_sh;
                        4'b1111: w_res = $unsigned($signed(r_b) >>> w_sh);
                        default: w_res = '0;
                    endcase
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid)                   w_state_nxt = S_EXEC;
            S_EXEC: if (!w_is_cnt || w_last_chunk)  w_state_nxt = S_DONE;
            S_DONE: if (out_ready)                  w_state_nxt = S_IDLE;
            default:                                w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, chunk counting and result/flag registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_cnt_src     <= '0;
            r_chunks_left <= '0;
            r_acc         <= '0;
            r_s           <= '0;
            r_z           <= 1'b0;
            r_c           <= 1'b0;
            r_v           <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a           <= a;
                r_b           <= b;
                r_op          <= aluc;
                r_cnt_src     <= (aluc == OP_HAM) ? (a ^ b) : a;
                r_chunks_left <= CW'(NCHUNK - 1);
                r_acc         <= '0;
            end
            if (r_state == S_EXEC) begin
                if (w_is_cnt) begin
                    r_cnt_src     <= r_cnt_src >> CHUNK;
                    r_acc         <= w_cnt_sum;
                    r_chunks_left <= r_chunks_left - 1'b1;
                    if (w_last_chunk) begin
                        r_s <= w_cnt_sum;
                        r_z <= (w_cnt_sum == '0);
                        r_c <= 1'b0;
                        r_v <= 1'b0;
                    end
                end else begin
                    r_s <= w_res;
                    r_z <= (w_res == '0);
                    r_c <= w_c;
                    r_v <= w_v;
                end
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign s         = r_s;
    assign z         = r_z;
    assign c         = r_c;
    assign v         = r_v;

endmodule
